icap_readback_ctrl: RTL
=======================

# icap_readback_ctrl

Drives a Xilinx 7-series ICAPE2 in the read direction. It issues a fixed type-1 register-read command sequence over the ICAP write port, switches the port to read, and captures the returned 32-bit words. The words are packed into 128-bit beats for the SoC. It is the return path to the AES → fifo128to32 → ICAP write path: it reads configuration registers (IDCODE, STAT, …) back for verification.

## Interface
Parameters:
- RD_LATENCY, 3: cycles from the first CSIB-low read cycle until `icap_o` carries the first valid word.
- MAX_WORDS, 1024: largest accepted `word_count`.

Ports:
- clk  in  1  system clock, same as the ICAP clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- reg_addr  in  5  configuration register address; latched on start.
- word_count  in  11  words to read, 1..MAX_WORDS; latched on start.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse at the end of the sequence.
- icap_csib  out  1  to ICAPE2 CSIB, active low.
- icap_rdwrb  out  1  to ICAPE2 RDWRB; 0 = write, 1 = read.
- icap_i  out  32  to ICAPE2 I.
- icap_o  in  32  from ICAPE2 O.
- data_out  out  128  packed readback beat.
- data_valid  out  1  one-cycle strobe qualifying `data_out`.

## Operation
- All outputs are registered. Reset values:
  - csib=1, rdwrb=0, icap_i=0
  - busy=0, done=0
  - data_out=0, data_valid=0
- States: IDLE → WR_HDR → SW_RD → RD → SW_WR → WR_TAIL → DONE → IDLE.
- IDLE: on `start` with 1 ≤ word_count ≤ MAX_WORDS, latch the inputs and go to WR_HDR. Otherwise stay in IDLE; no output changes.
- WR_HDR: csib=0, rdwrb=0; emit 6 words, one per cycle, in this order:
  - FFFFFFFF
  - AA995566
  - 20000000
  - 28000000 | reg_addr<<13 | word_count
  - 20000000
  - 20000000
- SW_RD: one cycle with csib=1, rdwrb=1.
- RD:
  - csib=0, rdwrb=1 for exactly RD_LATENCY+word_count cycles.
  - Word k (0-based) is sampled from `icap_o` in RD cycle RD_LATENCY+k.
- Packing:
  - Word 0 of each beat goes to [127:96], word 3 to [31:0].
  - `data_valid` pulses the cycle after the 4th word of a beat is captured.
  - A final partial beat is zero-padded in its low words and emitted the cycle after the last word.
  - `data_out` holds its value until the next beat.
- SW_WR: one cycle with csib=1, rdwrb=0.
- WR_TAIL: csib=0, rdwrb=0; emit 30008001, 0000000D (DESYNC), 20000000, 20000000.
- DONE: csib=1; `done`=1 for one cycle; `busy` drops in the same cycle `done` is high.
- Boundary behaviour:
  - start while busy: ignored.
  - start together with rst: rst wins.
  - word_count=0 or word_count>MAX_WORDS: start ignored.
- Reset mid-operation:
  - Next edge: csib=1, rdwrb=0, state IDLE, any partial beat discarded, no done pulse.
  - The config logic may be left synced; software must reissue a full sequence.
- Bit-swapping of ICAP data is outside this block. Words pass through unmodified.

## Timing
- Let start accepted at edge 0, L=RD_LATENCY, N=word_count.
- WR_HDR: cycles 1–6.
- SW_RD: cycle 7.
- RD: cycles 8…7+L+N; word k captured at cycle 8+L+k.
- SW_WR: cycle 8+L+N.
- WR_TAIL: cycles 9+L+N…12+L+N.
- done: cycle 13+L+N. Earliest next accepted start: cycle 14+L+N.
- data_valid for the beat containing word k=4m+3 (or the last word): cycle 9+L+k.
- csib never has a low-to-low rdwrb change. rdwrb changes only while csib=1.

## Structure
- Package `icap_pkg`:
  - constants DUMMY, SYNC, NOOP, CMD_WR_HDR (30008001), DESYNC_CODE (0000000D)
  - function `type1_rd_hdr(addr, count)`
  - state enum
- Sub-module `pack32to128`, the counterpart of fifo128to32:
  - inputs: word, word_valid, last
  - outputs: data_out, data_valid
  - clear on rst
- Top-level integration (sharing ICAPE2 with the write path, arbitrating csib) is out of scope.

## Test plan
The bench uses an ICAP behavioural model: it checks the write words and returns a programmed pattern after L cycles.

- IDCODE read: L=3, reg_addr=0C, N=1.
  - Header 28018001 in cycle 4.
  - data_valid at cycle 12 with {03651093, 96'h0}.
  - done at cycle 17.
- Burst: N=9, pattern words 1..9.
  - Three data_valid pulses: {1,2,3,4}, {5,6,7,8}, {9,0,0,0}.
  - Second pulse exactly 4 cycles after the first.
- Illegal start: word_count=0, and separately word_count=1025.
  - busy stays 0, csib stays 1, no done.
- start pulsed every cycle during a transfer.
  - Only the first is accepted; exactly one done.
- rst asserted in RD at word 2 of N=8.
  - Next cycle: csib=1, rdwrb=0, busy=0, no data_valid, no done.
  - A fresh start then completes correctly.
- Protocol check over all runs.
  - rdwrb toggles only while csib=1.
  - WR_TAIL words appear in order 30008001, 0000000D, 20000000, 20000000.

Source files
------------

// File: rtl/icap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icap_pkg
//  Description : Shared constants, type-1 header helper and FSM state
//                encoding for the ICAPE2 readback controller.
//  Revision    : 1.0  initial release
// ============================================================================
package icap_pkg;

    // Configuration command words (already in ICAP bit order).
    localparam logic [31:0] DUMMY       = 32'hFFFF_FFFF;
    localparam logic [31:0] SYNC        = 32'hAA99_5566;
    localparam logic [31:0] NOOP        = 32'h2000_0000;
    localparam logic [31:0] CMD_WR_HDR  = 32'h3000_8001;
    localparam logic [31:0] DESYNC_CODE = 32'h0000_000D;

    // Number of words in the write-side header and tail sequences.
    localparam int HDR_WORDS  = 6;
    localparam int TAIL_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_HDR  = 3'd1,
        ST_SW_RD   = 3'd2,
        ST_RD      = 3'd3,
        ST_SW_WR   = 3'd4,
        ST_WR_TAIL = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Type-1 packet header: opcode READ, register address in [17:13],
    // word count in [10:0].
    function automatic logic [31:0] type1_rd_hdr(input logic [4:0]  addr,
                                                 input logic [10:0] count);
        return 32'h2800_0000 | {14'd0, addr, 13'd0} | {21'd0, count};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pack32to128.sv
`default_nettype none
// ============================================================================
//  Module      : pack32to128
//  Description : Packs 32-bit words into 128-bit beats, first word in the
//                most significant slot. A beat is emitted on the 4th word or
//                on a word flagged 'last' (remaining slots zero).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                word            - incoming 32-bit word
//                word_valid      - qualifies word this cycle
//                last            - word is the final one of the transfer
//                data_out        - packed beat, held until the next beat
//                data_valid      - one-cycle strobe qualifying data_out
//  Revision    : 1.0  initial release
// ============================================================================
module pack32to128 (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  word,
    input  logic         word_valid,
    input  logic         last,
    output logic [127:0] data_out,
    output logic         data_valid
);

    logic [127:0] r_acc;
    logic [1:0]   r_cnt;
    logic [127:0] w_merged;

    // Accumulator with the incoming word dropped into its slot; unused
    // lower slots stay zero because r_acc is cleared after every beat.
    always_comb begin
        w_merged = r_acc;
        case (r_cnt)
            2'd0:    w_merged[127:96] = word;
            2'd1:    w_merged[95:64]  = word;
            2'd2:    w_merged[63:32]  = word;
            default: w_merged[31:0]   = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (word_valid) begin
                if (r_cnt == 2'd3 || last) begin
                    data_out   <= w_merged;
                    data_valid <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_merged;
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/icap_readback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icap_readback_ctrl
//  Description : Reads a configuration register back through ICAPE2:
//                writes a type-1 read header, turns the port around, captures
//                word_count words after RD_LATENCY cycles, turns the port back
//                and writes a DESYNC tail. Words are packed into 128-bit beats.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                start, reg_addr,
//                word_count              - request (accepted only when idle)
//                busy, done              - status
//                icap_csib, icap_rdwrb,
//                icap_i, icap_o          - ICAPE2 interface
//                data_out, data_valid    - packed readback beats
//  Revision    : 1.0  initial release
// ============================================================================
module icap_readback_ctrl
    import icap_pkg::*;
#(
    parameter int RD_LATENCY = 3,
    parameter int MAX_WORDS  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   reg_addr,
    input  logic [10:0]  word_count,
    output logic         busy,
    output logic         done,
    output logic         icap_csib,
    output logic         icap_rdwrb,
    output logic [31:0]  icap_i,
    input  logic [31:0]  icap_o,
    output logic [127:0] data_out,
    output logic         data_valid
);

    localparam logic [11:0] C_LAT = 12'(RD_LATENCY);
    localparam logic [11:0] C_MAX = 12'(MAX_WORDS);

    state_t      r_state;
    logic [2:0]  r_idx;       // index of the next header/tail word to emit
    logic [11:0] r_rd_cnt;    // index of the read cycle currently on the port
    logic [4:0]  r_addr;
    logic [10:0] r_n;

    logic        w_start_ok;
    logic [31:0] w_hdr_word;
    logic [31:0] w_tail_word;
    logic        w_word_valid;
    logic        w_rd_last;

    assign w_start_ok = start && (word_count != 11'd0) &&
                        ({1'b0, word_count} <= C_MAX);

    always_comb begin
        w_hdr_word = NOOP;
        case (r_idx)
            3'd0:    w_hdr_word = DUMMY;
            3'd1:    w_hdr_word = SYNC;
            3'd2:    w_hdr_word = NOOP;
            3'd3:    w_hdr_word = type1_rd_hdr(r_addr, r_n);
            default: w_hdr_word = NOOP;
        endcase
    end

    always_comb begin
        w_tail_word = NOOP;
        case (r_idx)
            3'd0:    w_tail_word = CMD_WR_HDR;
            3'd1:    w_tail_word = DESYNC_CODE;
            default: w_tail_word = NOOP;
        endcase
    end

    // The ICAP returns word k during read cycle RD_LATENCY+k; the last read
    // cycle carries the final word.
    assign w_word_valid = (r_state == ST_RD) && (r_rd_cnt >= C_LAT);
    assign w_rd_last    = (r_rd_cnt == (C_LAT + {1'b0, r_n} - 12'd1));

    // r_state names the phase whose outputs are currently on the pins;
    // csib is always high on the cycles where rdwrb changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_rd_cnt   <= '0;
            r_addr     <= '0;
            r_n        <= '0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b0;
            icap_i     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_addr    <= reg_addr;
                        r_n       <= word_count;
                        r_state   <= ST_WR_HDR;
                        icap_csib <= 1'b0;
                        icap_rdwrb <= 1'b0;
                        icap_i    <= DUMMY;
                        r_idx     <= 3'd1;
                        busy      <= 1'b1;
                    end
                end
                ST_WR_HDR: begin
                    if (r_idx == 3'(HDR_WORDS)) begin
                        r_state    <= ST_SW_RD;
                        icap_csib  <= 1'b1;
                        icap_rdwrb <= 1'b1;
                        icap_i     <= '0;
                    end else begin
                        icap_i <= w_hdr_word;
                        r_idx  <= r_idx + 3'd1;
                    end
                end
                ST_SW_RD: begin
                    r_state   <= ST_RD;
                    icap_csib <= 1'b0;
                    r_rd_cnt  <= '0;
                end
                ST_RD: begin
                    if (w_rd_last) begin
                        r_state    <= ST_SW_WR;
                        icap_csib  <= 1'b1;
                        icap_rdwrb <= 1'b0;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 12'd1;
                    end
                end
                ST_SW_WR: begin
                    r_state   <= ST_WR_TAIL;
                    icap_csib <= 1'b0;
                    icap_i    <= CMD_WR_HDR;
                    r_idx     <= 3'd1;
                end
                ST_WR_TAIL: begin
                    if (r_idx == 3'(TAIL_WORDS)) begin
                        r_state   <= ST_DONE;
                        icap_csib <= 1'b1;
                        icap_i    <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        icap_i <= w_tail_word;
                        r_idx  <= r_idx + 3'd1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pack32to128 u_pack (
        .clk        (clk),
        .rst        (rst),
        .word       (icap_o),
        .word_valid (w_word_valid),
        .last       (w_rd_last),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

endmodule
`default_nettype wire
